// File: rtl/dmem_wait_responder_pkg.sv
// Shared encodings and widths for the wait-state data-memory responder.
package dmem_wait_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte synchronous write and a registered read port.
module dmem_array
    import dmem_wait_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     widx_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     ridx_i,
    output logic [WORD_W-1:0] rdata_o
);

    // NOTE: storage has no reset branch; contents survive reset and only start from zero.
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[ridx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// Memory-stage data responder: latches one request, stalls for WAIT_CYCLES+1 cycles, then responds.
module dmem_wait_responder
    import dmem_wait_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              stall_m,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              addr_err
);

    localparam int               AW        = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef struct packed {
        logic              write;
        logic              err;
        logic [AW-1:0]     idx;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;

    logic [30:0]       word_off;
    logic              addr_bad;
    logic [AW-1:0]     rd_idx;
    logic              mem_we;
    logic [WORD_W-1:0] rd_data;

    // Word-granular offset; bit 30 is the borrow, set when the address lies below BASE_ADDR.
    assign word_off = {1'b0, req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign addr_bad = (req_addr[1:0] != 2'b00) | word_off[30] | (|word_off[29:AW]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // NOTE: every output is given a default before the case so no path leaves one unassigned.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rd_idx    = req_q.idx;
        mem_we    = 1'b0;
        stall_m   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        addr_err  = 1'b0;

        case (state_q)
            DMEM_IDLE: begin
                stall_m = req_valid;
                rd_idx  = word_off[AW-1:0];
                if (req_valid) begin
                    req_d   = '{write: req_write, err: addr_bad, idx: word_off[AW-1:0],
                                wdata: req_wdata, be: req_be};
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_DONE;
                end
            end
            DMEM_WAIT: begin
                stall_m = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                rsp_valid = 1'b1;
                addr_err  = req_q.err;
                rsp_rdata = (req_q.err || req_q.write) ? '0 : rd_data;
                mem_we    = req_q.write && !req_q.err;
                state_d   = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase

        // Reset aborts any in-flight access in the same cycle: no stall, no response, no write.
        if (reset) begin
            mem_we    = 1'b0;
            stall_m   = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            addr_err  = 1'b0;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk),
        .we_i   (mem_we),
        .be_i   (req_q.be),
        .widx_i (req_q.idx),
        .wdata_i(req_q.wdata),
        .ridx_i (rd_idx),
        .rdata_o(rd_data)
    );

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance share one clock.
module tb_dmem_wait_responder;

    typedef struct packed {
        logic        got;
        logic [3:0]  stalls;
        logic        err;
        logic [31:0] rdata;
    } res_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, v2, w2, stall2, rv2, err2;
    logic [31:0] a2, d2, rd2;
    logic [3:0]  be2;
    logic        rst0, v0, w0, stall0, rv0, err0;
    logic [31:0] a0, d0, rd0;
    logic [3:0]  be0;

    int checks = 0;
    int errors = 0;
    int rsp_cnt0 = 0;
    int rsp_cnt2 = 0;

    dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .reset(rst2), .req_valid(v2), .req_write(w2), .req_addr(a2),
        .req_wdata(d2), .req_be(be2), .stall_m(stall2), .rsp_valid(rv2),
        .rsp_rdata(rd2), .addr_err(err2)
    );

    dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(rst0), .req_valid(v0), .req_write(w0), .req_addr(a0),
        .req_wdata(d0), .req_be(be0), .stall_m(stall0), .rsp_valid(rv0),
        .rsp_rdata(rd0), .addr_err(err0)
    );

    always @(negedge clk) begin
        #2;
        if (rv0 === 1'b1) rsp_cnt0++;
        if (rv2 === 1'b1) rsp_cnt2++;
    end

    task automatic drive(input int which, input logic v, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (which == 0) begin
            v0 = v; w0 = wr; a0 = a; d0 = d; be0 = be;
        end else begin
            v2 = v; w2 = wr; a2 = a; d2 = d; be2 = be;
        end
    endtask

    task automatic idle(input int which, input int n);
        repeat (n) begin
            @(negedge clk);
            drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
    endtask

    // Presents one request and follows it until the response cycle (bounded to 40 cycles).
    task automatic access(input int which, input op_t op, input bit swap, input logic [31:0] alt,
                          output res_t r);
        logic st, rv, er;
        logic [31:0] rd;
        r = '0;
        @(negedge clk);
        drive(which, 1'b1, op.wr, op.addr, op.wdata, op.be);
        for (int cyc = 0; cyc < 40 && !r.got; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (swap) begin
                    if (which == 0) a0 = alt; else a2 = alt;
                end
            end
            #1;
            st = (which == 0) ? stall0 : stall2;
            rv = (which == 0) ? rv0 : rv2;
            er = (which == 0) ? err0 : err2;
            rd = (which == 0) ? rd0 : rd2;
            if (st === 1'b1 && r.stalls != 4'hF) r.stalls++;
            if (rv === 1'b1) begin
                r.got = 1'b1;
                r.err = er;
                r.rdata = op.wr ? 32'h0 : rd;
            end
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        rst2 = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF);
        drive(2, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({stall2, rv2, err2, rd2} !== 35'h0) begin
            errors++;
            $display("FAIL reset_w2: stall=%b rsp=%b err=%b rdata=%h, expected all zero", stall2, rv2, err2, rd2);
        end
        checks++;
        if ({stall0, rv0, err0, rd0} !== 35'h0) begin
            errors++;
            $display("FAIL reset_w0: stall=%b rsp=%b err=%b rdata=%h, expected all zero", stall0, rv0, err0, rd0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst2 = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        checks++;
        if ({stall2, rv2, stall0, rv0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: stall2=%b rsp2=%b stall0=%b rsp0=%b, expected 0000", stall2, rv2, stall0, rv0);
        end
    endtask

    task automatic test_store_load;
        op_t  ops [2];
        res_t exp [2];
        res_t r;
        ops[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF}; exp[0] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[1] = '{1'b0, 32'h10, 32'h0, 4'hF};         exp[1] = '{1'b1, 4'd3, 1'b0, 32'hDEAD_BEEF};
        for (int i = 0; i < 2; i++) begin
            access(2, ops[i], 1'b0, 32'h0, r);
            idle(2, 1);
            checks++;
            if (r !== exp[i]) begin
                errors++;
                $display("FAIL store_load[%0d]: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=%b stalls=%0d err=%b rdata=%h",
                         i, r.got, r.stalls, r.err, r.rdata, exp[i].got, exp[i].stalls, exp[i].err, exp[i].rdata);
            end
        end
    endtask

    task automatic test_byte_enables;
        op_t  ops [6];
        res_t exp [6];
        res_t r;
        ops[0] = '{1'b1, 32'h10, 32'h0000_00AA, 4'b0001}; exp[0] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[1] = '{1'b0, 32'h10, 32'h0,         4'b0000}; exp[1] = '{1'b1, 4'd3, 1'b0, 32'hDEAD_BEAA};
        ops[2] = '{1'b1, 32'h10, 32'h5555_5555, 4'b0000}; exp[2] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[3] = '{1'b0, 32'h10, 32'h0,         4'b1111}; exp[3] = '{1'b1, 4'd3, 1'b0, 32'hDEAD_BEAA};
        ops[4] = '{1'b1, 32'h14, 32'h1122_3344, 4'b1010}; exp[4] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[5] = '{1'b0, 32'h14, 32'h0,         4'b0101}; exp[5] = '{1'b1, 4'd3, 1'b0, 32'h1100_3300};
        for (int i = 0; i < 6; i++) begin
            access(2, ops[i], 1'b0, 32'h0, r);
            idle(2, 1);
            checks++;
            if (r !== exp[i]) begin
                errors++;
                $display("FAIL byte_en[%0d]: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=%b stalls=%0d err=%b rdata=%h",
                         i, r.got, r.stalls, r.err, r.rdata, exp[i].got, exp[i].stalls, exp[i].err, exp[i].rdata);
            end
        end
    endtask

    task automatic test_addr_err;
        op_t  ops [8];
        res_t exp [8];
        res_t r;
        ops[0] = '{1'b1, 32'h100,       32'h7777_7777, 4'hF}; exp[0] = '{1'b1, 4'd3, 1'b1, 32'h0};
        ops[1] = '{1'b1, 32'h11,        32'hF0F0_F0F0, 4'hF}; exp[1] = '{1'b1, 4'd3, 1'b1, 32'h0};
        ops[2] = '{1'b0, 32'h13,        32'h0,         4'hF}; exp[2] = '{1'b1, 4'd3, 1'b1, 32'h0};
        ops[3] = '{1'b0, 32'h100,       32'h0,         4'hF}; exp[3] = '{1'b1, 4'd3, 1'b1, 32'h0};
        ops[4] = '{1'b0, 32'h0,         32'h0,         4'hF}; exp[4] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[5] = '{1'b0, 32'h10,        32'h0,         4'hF}; exp[5] = '{1'b1, 4'd3, 1'b0, 32'hDEAD_BEAA};
        ops[6] = '{1'b0, 32'hFC,        32'h0,         4'hF}; exp[6] = '{1'b1, 4'd3, 1'b0, 32'h0};
        ops[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF}; exp[7] = '{1'b1, 4'd3, 1'b1, 32'h0};
        for (int i = 0; i < 8; i++) begin
            access(2, ops[i], 1'b0, 32'h0, r);
            idle(2, 1);
            checks++;
            if (r !== exp[i]) begin
                errors++;
                $display("FAIL addr_err[%0d]: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=%b stalls=%0d err=%b rdata=%h",
                         i, r.got, r.stalls, r.err, r.rdata, exp[i].got, exp[i].stalls, exp[i].err, exp[i].rdata);
            end
        end
    endtask

    task automatic test_addr_change;
        res_t r;
        access(2, '{1'b1, 32'h20, 32'h1234_5678, 4'hF}, 1'b0, 32'h0, r);
        idle(2, 1);
        checks++;
        if (r !== res_t'{1'b1, 4'd3, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL addr_change_store: rsp=%b stalls=%0d err=%b, expected rsp=1 stalls=3 err=0", r.got, r.stalls, r.err);
        end
        access(2, '{1'b0, 32'h10, 32'h0, 4'hF}, 1'b1, 32'h20, r);
        idle(2, 1);
        checks++;
        if (r !== res_t'{1'b1, 4'd3, 1'b0, 32'hDEAD_BEAA}) begin
            errors++;
            $display("FAIL addr_change_load: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=1 stalls=3 err=0 rdata=deadbeaa",
                     r.got, r.stalls, r.err, r.rdata);
        end
    endtask

    task automatic test_reset_mid;
        res_t r;
        int   base;
        access(2, '{1'b1, 32'h8, 32'h1122_3344, 4'hF}, 1'b0, 32'h0, r);
        idle(2, 1);
        checks++;
        if (r !== res_t'{1'b1, 4'd3, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_prestore: rsp=%b stalls=%0d err=%b, expected rsp=1 stalls=3 err=0", r.got, r.stalls, r.err);
        end
        base = rsp_cnt2;
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        checks++;
        if ({stall2, rv2} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_cycle: stall=%b rsp=%b, expected stall=0 rsp=0", stall2, rv2);
        end
        @(negedge clk);
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(2, 4);
        checks++;
        if (rsp_cnt2 - base !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: responses=%0d, expected 0", rsp_cnt2 - base);
        end
        access(2, '{1'b0, 32'h8, 32'h0, 4'hF}, 1'b0, 32'h0, r);
        idle(2, 1);
        checks++;
        if (r !== res_t'{1'b1, 4'd3, 1'b0, 32'h1122_3344}) begin
            errors++;
            $display("FAIL reset_mid_load: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=1 stalls=3 err=0 rdata=11223344",
                     r.got, r.stalls, r.err, r.rdata);
        end
    endtask

    task automatic test_back_to_back;
        res_t r;
        int   base;
        base = rsp_cnt0;
        access(0, '{1'b1, 32'h4, 32'hA5A5_0F0F, 4'hF}, 1'b0, 32'h0, r);
        checks++;
        if (r !== res_t'{1'b1, 4'd1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL b2b_store: rsp=%b stalls=%0d err=%b, expected rsp=1 stalls=1 err=0", r.got, r.stalls, r.err);
        end
        access(0, '{1'b0, 32'h4, 32'h0, 4'hF}, 1'b0, 32'h0, r);
        checks++;
        if (r !== res_t'{1'b1, 4'd1, 1'b0, 32'hA5A5_0F0F}) begin
            errors++;
            $display("FAIL b2b_load: rsp=%b stalls=%0d err=%b rdata=%h, expected rsp=1 stalls=1 err=0 rdata=a5a50f0f",
                     r.got, r.stalls, r.err, r.rdata);
        end
        idle(0, 3);
        #1;
        checks++;
        if (rsp_cnt0 - base !== 2) begin
            errors++;
            $display("FAIL b2b_rsp_count: responses=%0d, expected 2", rsp_cnt0 - base);
        end
        checks++;
        if ({stall0, rv0} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: stall=%b rsp=%b, expected stall=0 rsp=0", stall0, rv0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_addr_err();
        test_addr_change();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
